mspe_mem_arbiter: RTL and testbench

Shares the single 512-bit Avalon-MM DRAM master port of `mspe` among `CORES` requesters, such as per-core instruction/data loaders. Each requester issues single-beat writes or burst reads; the block grants requesters in round-robin order and runs exactly one transaction on `m0` at a time. Read beats are routed back to the requester that owns the burst. The block sits between the per-core loaders and the `m0_*` pins of `mspe`.

---
 rtl/mspe_mem_arbiter_pkg.sv | 30 +++
 rtl/mspe_rr_arbiter.sv | 52 +++++
 rtl/mspe_mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mspe_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mspe_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mspe_arb_pkg
// Purpose  : Shared types for the mspe DRAM master-port arbiter.
// Revision : 1.0
// ============================================================================
package mspe_arb_pkg;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_ISSUE = 2'd1;
    localparam logic [1:0] C_ST_RDATA = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = C_ST_IDLE,
        ISSUE = C_ST_ISSUE,
        RDATA = C_ST_RDATA
    } arb_state_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } cmd_t;

    // Reads with a zero burstcount are run as single-beat reads.
    function automatic logic [7:0] eff_burst(input logic [7:0] bc);
        return (bc == 8'd0) ? 8'd1 : bc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mspe_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mspe_rr_arbiter
// Purpose  : Round-robin picker; search starts one past the last grant.
// Revision : 1.0
// ============================================================================
module mspe_rr_arbiter #(
    parameter int CORES = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CORES-1:0] i_req,
    input  logic             i_update,
    output logic [CORES-1:0] o_grant_oh,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_grant_valid
);

    logic [IDX_W-1:0] r_last_grant;
    logic [IDX_W-1:0] w_cand;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        w_found = 1'b0;
        w_idx   = r_last_grant;
        w_cand  = '0;
        for (int k = 1; k <= CORES; k++) begin
            w_cand = IDX_W'((int'(r_last_grant) + k) % CORES);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    // Reset points just below requester 0 so it wins the first arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= IDX_W'(CORES - 1);
        end else if (i_update && w_found) begin
            r_last_grant <= w_idx;
        end
    end

    assign o_grant_valid = w_found;
    assign o_grant_idx   = w_idx;
    assign o_grant_oh    = w_found ? (CORES'(1) << w_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/mspe_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mspe_mem_arbiter
// Purpose  : Shares the 512-bit Avalon-MM m0 port among CORES requesters,
//            one transaction at a time. Macro MSPE_ARB_TIMEOUT_EN adds a
//            read-beat watchdog.
// Revision : 1.0
// ============================================================================
module mspe_mem_arbiter
    import mspe_arb_pkg::*;
#(
    parameter int CORES       = 4,
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 512,
    parameter int BURST_WIDTH = 3,
    parameter int TIMEOUT     = 4096
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [CORES-1:0]                req_read,
    input  logic [CORES-1:0]                req_write,
    input  logic [CORES*ADDR_WIDTH-1:0]     req_address,
    input  logic [CORES*BURST_WIDTH-1:0]    req_burstcount,
    input  logic [CORES*DATA_WIDTH-1:0]     req_writedata,
    input  logic [CORES*DATA_WIDTH/8-1:0]   req_byteenable,
    output logic [CORES-1:0]                req_ack,
    output logic [CORES-1:0]                rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            busy,
    output logic                            err_timeout,
    input  logic                            m0_waitrequest,
    input  logic [DATA_WIDTH-1:0]           m0_readdata,
    input  logic                            m0_readdatavalid,
    output logic [ADDR_WIDTH-1:0]           m0_address,
    output logic [BURST_WIDTH-1:0]          m0_burstcount,
    output logic [DATA_WIDTH-1:0]           m0_writedata,
    output logic [DATA_WIDTH/8-1:0]         m0_byteenable,
    output logic                            m0_read,
    output logic                            m0_write,
    output logic                            m0_debugaccess
);

    localparam int IDX_W = (CORES > 1) ? $clog2(CORES) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;

    logic [CORES-1:0]       w_req_any;
    logic [CORES-1:0]       w_grant_oh;
    logic [IDX_W-1:0]       w_grant_idx;
    logic                   w_grant_valid;
    logic                   w_grant_upd;

    logic                   w_sel_rd;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [BURST_WIDTH-1:0] w_sel_bc;
    logic [BURST_WIDTH-1:0] w_eff_bc;
    logic [DATA_WIDTH-1:0]  w_sel_wd;
    logic [BE_W-1:0]        w_sel_be;

    arb_state_t             r_state;
    cmd_t                   r_cmd;
    logic [CORES-1:0]       r_owner_oh;
    logic [BURST_WIDTH-1:0] r_beats;

    logic [ADDR_WIDTH-1:0]  r_m0_address;
    logic [BURST_WIDTH-1:0] r_m0_burstcount;
    logic [DATA_WIDTH-1:0]  r_m0_writedata;
    logic [BE_W-1:0]        r_m0_byteenable;
    logic                   r_m0_read;
    logic                   r_m0_write;
    logic [CORES-1:0]       r_req_ack;
    logic [CORES-1:0]       r_rd_valid;
    logic [DATA_WIDTH-1:0]  r_rd_data;

`ifdef MSPE_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]       r_tmo_cnt;
    logic                   r_err;
`endif

    assign w_req_any   = req_read | req_write;
    assign w_grant_upd = (r_state == IDLE) && w_grant_valid;

    mspe_rr_arbiter #(
        .CORES (CORES),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk           (clk),
        .rst           (reset),
        .i_req         (w_req_any),
        .i_update      (w_grant_upd),
        .o_grant_oh    (w_grant_oh),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    // A requester asserting both read and write is served as a read.
    assign w_sel_rd   = req_read[w_grant_idx];
    assign w_sel_addr = req_address[int'(w_grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_bc   = req_burstcount[int'(w_grant_idx) * BURST_WIDTH +: BURST_WIDTH];
    assign w_sel_wd   = req_writedata[int'(w_grant_idx) * DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_be   = req_byteenable[int'(w_grant_idx) * BE_W +: BE_W];
    assign w_eff_bc   = BURST_WIDTH'(eff_burst(8'(w_sel_bc)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_cmd           <= RD;
            r_owner_oh      <= '0;
            r_beats         <= '0;
            r_m0_address    <= '0;
            r_m0_burstcount <= '0;
            r_m0_writedata  <= '0;
            r_m0_byteenable <= '0;
            r_m0_read       <= 1'b0;
            r_m0_write      <= 1'b0;
            r_req_ack       <= '0;
            r_rd_valid      <= '0;
            r_rd_data       <= '0;
`ifdef MSPE_ARB_TIMEOUT_EN
            r_tmo_cnt       <= '0;
            r_err           <= 1'b0;
`endif
        end else begin
            r_req_ack  <= '0;
            r_rd_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner_oh      <= w_grant_oh;
                        r_cmd           <= w_sel_rd ? RD : WR;
                        r_m0_address    <= w_sel_addr;
                        r_m0_writedata  <= w_sel_wd;
                        r_m0_burstcount <= w_sel_rd ? w_eff_bc : BURST_WIDTH'(1);
                        r_m0_byteenable <= w_sel_rd ? {BE_W{1'b1}} : w_sel_be;
                        r_m0_read       <= w_sel_rd;
                        r_m0_write      <= !w_sel_rd;
                        r_state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!m0_waitrequest) begin
                        r_m0_read  <= 1'b0;
                        r_m0_write <= 1'b0;
                        r_req_ack  <= r_owner_oh;
                        r_beats    <= r_m0_burstcount;
                        r_state    <= (r_cmd == RD) ? RDATA : IDLE;
`ifdef MSPE_ARB_TIMEOUT_EN
                        r_tmo_cnt  <= '0;
`endif
                    end
                end
                RDATA: begin
                    if (m0_readdatavalid) begin
                        r_rd_data  <= m0_readdata;
                        r_rd_valid <= r_owner_oh;
                        r_beats    <= r_beats - BURST_WIDTH'(1);
                        if (r_beats == BURST_WIDTH'(1)) begin
                            r_state <= IDLE;
                        end
                    end
`ifdef MSPE_ARB_TIMEOUT_EN
                    // Watchdog restarts on every beat; expiry abandons the burst.
                    if (m0_readdatavalid) begin
                        r_tmo_cnt <= '0;
                    end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MSPE_ARB_TIMEOUT_EN
    assign err_timeout = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign err_timeout      = 1'b0;
`endif

    assign busy           = (r_state != IDLE);
    assign req_ack        = r_req_ack;
    assign rd_valid       = r_rd_valid;
    assign rd_data        = r_rd_data;
    assign m0_address     = r_m0_address;
    assign m0_burstcount  = r_m0_burstcount;
    assign m0_writedata   = r_m0_writedata;
    assign m0_byteenable  = r_m0_byteenable;
    assign m0_read        = r_m0_read;
    assign m0_write       = r_m0_write;
    assign m0_debugaccess = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_mspe_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mspe_mem_arbiter
// Purpose  : Self-checking bench for mspe_mem_arbiter with a queue-free
//            round-robin reference model and randomized traffic.
// Revision : 1.0
// ============================================================================
module tb_mspe_mem_arbiter;

    localparam int CORES = 4;
    localparam int AW    = 64;
    localparam int DW    = 512;
    localparam int BW    = 3;
    localparam int BEW   = DW / 8;
    localparam int TMO   = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [CORES-1:0]      req_read, req_write;
    logic [CORES*AW-1:0]   req_address;
    logic [CORES*BW-1:0]   req_burstcount;
    logic [CORES*DW-1:0]   req_writedata;
    logic [CORES*BEW-1:0]  req_byteenable;
    logic [CORES-1:0]      req_ack, rd_valid;
    logic [DW-1:0]         rd_data;
    logic                  busy, err_timeout;
    logic                  m0_waitrequest;
    logic [DW-1:0]         m0_readdata;
    logic                  m0_readdatavalid;
    logic [AW-1:0]         m0_address;
    logic [BW-1:0]         m0_burstcount;
    logic [DW-1:0]         m0_writedata;
    logic [BEW-1:0]        m0_byteenable;
    logic                  m0_read, m0_write, m0_debugaccess;

    always #5 clk = ~clk;

    mspe_mem_arbiter #(
        .CORES(CORES), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BURST_WIDTH(BW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_burstcount(req_burstcount),
        .req_writedata(req_writedata), .req_byteenable(req_byteenable),
        .req_ack(req_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .err_timeout(err_timeout),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m0_address(m0_address), .m0_burstcount(m0_burstcount),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_debugaccess(m0_debugaccess)
    );

    // Requester-side view: what each core is currently asking for.
    bit            p_rd [CORES];
    bit            p_wr [CORES];
    logic [AW-1:0] p_addr [CORES];
    logic [BW-1:0] p_bc [CORES];
    logic [DW-1:0] p_wd [CORES];
    logic [BEW-1:0] p_be [CORES];
    int            last_grant;
    int            checks = 0;
    int            errors = 0;
    int            who;
    logic [DW-1:0] d;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_dw();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < CORES; i++) begin
            req_read[i]                 = p_rd[i];
            req_write[i]                = p_wr[i];
            req_address[i*AW +: AW]     = p_addr[i];
            req_burstcount[i*BW +: BW]  = p_bc[i];
            req_writedata[i*DW +: DW]   = p_wd[i];
            req_byteenable[i*BEW +: BEW] = p_be[i];
        end
    endtask

    task automatic set_req(input int i, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [BW-1:0] bc);
        p_rd[i] = rd; p_wr[i] = wr; p_addr[i] = a; p_bc[i] = bc;
        p_wd[i] = rand_dw();
        p_be[i] = {$urandom, $urandom};
    endtask

    task automatic new_rand_req(input int i);
        int kind;
        kind = $urandom_range(0, 2);
        set_req(i, kind != 1, kind != 0, {$urandom, $urandom}, BW'($urandom_range(0, 7)));
    endtask

    // Next owner: first pending core at or after last_grant+1, modulo CORES.
    function automatic int pick();
        for (int k = 1; k <= CORES; k++) begin
            if (p_rd[(last_grant + k) % CORES] || p_wr[(last_grant + k) % CORES])
                return (last_grant + k) % CORES;
        end
        return -1;
    endfunction

    task automatic chk_reset_vals(input string p);
        chk({p, "_m0_read"}, m0_read, 0);
        chk({p, "_m0_write"}, m0_write, 0);
        chk({p, "_m0_address"}, m0_address, 0);
        chk({p, "_m0_burstcount"}, m0_burstcount, 0);
        chk({p, "_m0_writedata"}, m0_writedata, 0);
        chk({p, "_m0_byteenable"}, m0_byteenable, 0);
        chk({p, "_m0_debugaccess"}, m0_debugaccess, 0);
        chk({p, "_req_ack"}, req_ack, 0);
        chk({p, "_rd_valid"}, rd_valid, 0);
        chk({p, "_rd_data"}, rd_data, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_err_timeout"}, err_timeout, 0);
    endtask

    // Entered at a negedge with the DUT idle and requests driven.
    // rearm: 0 drop, 1 re-request a 1-beat read, 2 maybe a new random request.
    task automatic run_txn(input int stall, input int gap_max, input int rearm, output int g);
        bit            is_rd, v;
        int            beats, got;
        logic [CORES-1:0] oh;
        logic [BEW-1:0] ones;
        logic [BEW-1:0] exp_be;
        g = pick();
        if (g < 0) begin
            $display("FAIL bench_no_pending_request observed=none expected=one");
            $fatal(1, "no pending request");
        end
        ones   = '1;
        oh     = CORES'(1) << g;
        is_rd  = p_rd[g];
        beats  = is_rd ? ((p_bc[g] == 0) ? 1 : int'(p_bc[g])) : 1;
        exp_be = is_rd ? ones : p_be[g];
        m0_waitrequest   = $urandom_range(0, 1);
        m0_readdatavalid = $urandom_range(0, 1);
        @(negedge clk);
        last_grant = g;
        chk("cmd_read", m0_read, is_rd);
        chk("cmd_write", m0_write, !is_rd);
        chk("cmd_addr", m0_address, p_addr[g]);
        chk("cmd_burst", m0_burstcount, beats);
        chk("cmd_be", m0_byteenable, exp_be);
        if (!is_rd) chk("cmd_wdata", m0_writedata, p_wd[g]);
        chk("cmd_debug", m0_debugaccess, 0);
        chk("cmd_busy", busy, 1);
        chk("cmd_no_ack", req_ack, 0);
        chk("idle_rdv_ignored", rd_valid, 0);
        for (int j = 1; j <= stall + 1; j++) begin
            m0_waitrequest   = (j <= stall);
            m0_readdatavalid = $urandom_range(0, 1);
            m0_readdata      = rand_dw();
            @(negedge clk);
            if (j <= stall) begin
                chk("stall_cmd", is_rd ? m0_read : m0_write, 1);
                chk("stall_addr", m0_address, p_addr[g]);
                chk("stall_be", m0_byteenable, exp_be);
                if (!is_rd) chk("stall_wdata", m0_writedata, p_wd[g]);
                chk("stall_ack", req_ack, 0);
                chk("stall_rdv", rd_valid, 0);
            end
        end
        chk("ack", req_ack, oh);
        chk("ack_read_low", m0_read, 0);
        chk("ack_write_low", m0_write, 0);
        chk("ack_rdv", rd_valid, 0);
        m0_readdatavalid = 1'b0;
        p_rd[g] = 1'b0;
        p_wr[g] = 1'b0;
        if (rearm == 1) set_req(g, 1, 0, {$urandom, $urandom}, 3'd1);
        if (rearm == 2 && $urandom_range(0, 1) == 1) new_rand_req(g);
        drive_reqs();
        if (!is_rd) begin
            chk("wr_done_idle", busy, 0);
        end else begin
            got = 0;
            while (got < beats) begin
                v = ($urandom_range(0, gap_max) == 0);
                d = rand_dw();
                m0_readdatavalid = v;
                m0_readdata      = d;
                @(negedge clk);
                chk("beat_valid", rd_valid, v ? oh : '0);
                if (v) begin
                    chk("beat_data", rd_data, d);
                    got++;
                end
                chk("beat_ack_clear", req_ack, 0);
            end
            m0_readdatavalid = 1'b0;
            chk("rd_done_idle", busy, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        m0_waitrequest = 1'b0;
        m0_readdatavalid = 1'b0;
        m0_readdata = '0;
        for (int i = 0; i < CORES; i++) set_req(i, 0, 0, '0, '0);
        drive_reqs();
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        last_grant = CORES - 1;

        // Single 4-beat read from requester 2.
        set_req(2, 1, 0, 64'h1000, 3'd4);
        drive_reqs();
        run_txn(0, 0, 0, who);

        // Write from requester 1 stalled by waitrequest for 5 cycles.
        set_req(1, 0, 1, 64'hdead_beef_0040, 3'd5);
        drive_reqs();
        run_txn(5, 0, 0, who);

        // Zero burstcount runs as a single beat.
        set_req(3, 1, 0, 64'h0300, 3'd0);
        drive_reqs();
        run_txn(1, 0, 0, who);

        // Read and write on one requester: read is issued.
        set_req(0, 1, 1, 64'h0abc, 3'd2);
        drive_reqs();
        run_txn(0, 1, 0, who);

        // Reset in the middle of a 4-beat burst.
        set_req(0, 1, 0, 64'h3000, 3'd4);
        drive_reqs();
        m0_waitrequest = 1'b0;
        @(negedge clk);
        chk("mid_cmd", m0_read, 1);
        @(negedge clk);
        chk("mid_ack", req_ack, 4'b0001);
        p_rd[0] = 1'b0;
        drive_reqs();
        for (int b = 0; b < 2; b++) begin
            d = rand_dw();
            m0_readdatavalid = 1'b1;
            m0_readdata = d;
            @(negedge clk);
            chk("mid_beat_valid", rd_valid, 4'b0001);
            chk("mid_beat_data", rd_data, d);
        end
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midreset");
        reset = 1'b0;
        last_grant = CORES - 1;
        for (int b = 0; b < 3; b++) begin
            m0_readdatavalid = 1'b1;
            m0_readdata = rand_dw();
            @(negedge clk);
            chk("post_reset_rdv", rd_valid, 0);
            chk("post_reset_busy", busy, 0);
        end
        m0_readdatavalid = 1'b0;

        // All cores keep issuing 1-beat reads: service rotates 0,1,2,3,0.
        for (int i = 0; i < CORES; i++) set_req(i, 1, 0, {$urandom, $urandom}, 3'd1);
        drive_reqs();
        for (int k = 0; k < 5; k++) run_txn(0, 0, 1, who);
        for (int i = 0; i < CORES; i++) begin
            p_rd[i] = 1'b0;
            p_wr[i] = 1'b0;
        end
        drive_reqs();
        @(negedge clk);

`ifdef MSPE_ARB_TIMEOUT_EN
        // Read that never returns data trips the watchdog.
        set_req(1, 1, 0, 64'h2000, 3'd2);
        drive_reqs();
        m0_waitrequest = 1'b0;
        @(negedge clk);
        last_grant = 1;
        chk("tmo_cmd", m0_read, 1);
        @(negedge clk);
        chk("tmo_ack", req_ack, 4'b0010);
        p_rd[1] = 1'b0;
        drive_reqs();
        repeat (TMO - 1) @(negedge clk);
        chk("tmo_not_yet", err_timeout, 0);
        chk("tmo_still_busy", busy, 1);
        @(negedge clk);
        chk("tmo_err", err_timeout, 1);
        chk("tmo_idle", busy, 0);
        m0_readdatavalid = 1'b1;
        m0_readdata = rand_dw();
        @(negedge clk);
        m0_readdatavalid = 1'b0;
        chk("tmo_late_beat", rd_valid, 0);
        set_req(2, 0, 1, 64'h2200, 3'd1);
        drive_reqs();
        run_txn(0, 0, 0, who);
        chk("tmo_sticky", err_timeout, 1);
`endif

        // Randomized traffic checked against the round-robin model.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < CORES; i++)
                if (!p_rd[i] && !p_wr[i] && $urandom_range(0, 1) == 1) new_rand_req(i);
            if (pick() < 0) new_rand_req($urandom_range(0, CORES - 1));
            drive_reqs();
            run_txn($urandom_range(0, 3), 2, 2, who);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
